// File: rtl/fifo_rd_drain_if.sv
// Handshake bundle between fifo_rd_drain, the async FIFO read port and the downstream stream sink.
// master = drain side (issues reads, drives the stream); slave = FIFO/sink side.
interface fifo_rd_drain_if #(
  parameter int unsigned WIDTH = 16
);
  logic             fifo_rd_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd_error;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_ready;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_rdata,
    input  fifo_rd_error,
    output m_valid,
    output m_data,
    input  m_ready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_rdata,
    output fifo_rd_error,
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/fifo_rd_drain.sv
// Read-domain drain of the async FIFO, re-presented as a 2-deep buffered valid/ready stream.
// Define FIFO_RD_DRAIN_BEAT_CNT_EN to enable the 16-bit accepted-beat counter on beat_cnt_o.
module fifo_rd_drain #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             rd_clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  fifo_rd_drain_if.master  io,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [15:0]      beat_cnt_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             valid;
  logic             push;
  logic             pop;

  assign valid = (occ != 2'd0);
  assign push  = (state == CAPTURE);
  assign pop   = valid && io.m_ready;

  assign io.fifo_rd_en = (state == ISSUE);
  assign io.m_valid    = valid;
  assign io.m_data     = head;

  // ISSUE -> CAPTURE -> IDLE spaces reads three cycles apart, so the lagged
  // empty flag sampled in IDLE already reflects the previous read.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en_i && !io.fifo_empty && (occ < 2'd2)) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // head is always the oldest word; a simultaneous push/pop shifts tail forward.
  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= io.fifo_rdata;
          else             tail <= io.fifo_rdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head <= io.fifo_rdata;
          end else begin
            head <= tail;
            tail <= io.fifo_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
    end else if (io.fifo_rd_error && (err_cnt_o != '1)) begin
      err_cnt_o <= err_cnt_o + ERR_W'(1);
    end
  end

`ifdef FIFO_RD_DRAIN_BEAT_CNT_EN
  logic [15:0] beat_cnt;

  always_ff @(posedge rd_clk_i) begin
    if (rst_i) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

  assign beat_cnt_o = beat_cnt;
`else
  assign beat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Self-checking bench for fifo_rd_drain: FIFO read-port model with lagged empty, scoreboard on the stream.
module tb_fifo_rd_drain;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned ERR_W = 8;
`ifdef FIFO_RD_DRAIN_BEAT_CNT_EN
  localparam bit BEAT_EN = 1'b1;
`else
  localparam bit BEAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [ERR_W-1:0] err_cnt;
  logic [15:0]      beat_cnt;

  int checks = 0;
  int errors = 0;

  fifo_rd_drain_if #(.WIDTH(WIDTH)) io ();

  fifo_rd_drain #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .rd_clk_i  (clk),
    .rst_i     (rst),
    .en_i      (en),
    .io        (io),
    .err_cnt_o (err_cnt),
    .beat_cnt_o(beat_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: contents in fifo_mem[rd_ptr..wr_ptr-1]; empty is registered from
  // the pre-read occupancy so it lags a read by one cycle; rdata is registered.
  logic [WIDTH-1:0] fifo_mem [0:4095];
  int unsigned      wr_ptr;
  int unsigned      rd_ptr = 0;
  int unsigned      cyc = 0;
  logic             model_err = 1'b0;
  logic             force_err;

  assign io.fifo_rd_error = model_err | force_err;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    io.fifo_empty <= (wr_ptr == rd_ptr);
    model_err <= 1'b0;
    if (io.fifo_rd_en === 1'b1) begin
      if (wr_ptr == rd_ptr) begin
        model_err <= 1'b1;
      end else begin
        io.fifo_rdata <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  // Monitor state (written only by the monitor task)
  int unsigned      out_ptr = 0;
  int unsigned      hs_cnt = 0;
  logic [WIDTH-1:0] out_log[$];
  int unsigned      tq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic wait_rd(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      seen = (io.fifo_rd_en === 1'b1);
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic count_rd(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (io.fifo_rd_en === 1'b1) pulses++;
    end
  endtask

  // Stream-rule checks every cycle: ordering, hold under backpressure, read pacing,
  // never reading an empty FIFO, at most two words owed downstream.
  task automatic monitor();
    bit               prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    bit               have_rd = 1'b0;
    int unsigned      last_rd = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        out_ptr = rd_ptr + ((io.fifo_rd_en === 1'b1) ? 1 : 0);
        prev_stall = 1'b0;
        have_rd = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, io.m_valid}, 32'd1);
          chk("hold_data", {16'd0, io.m_data}, {16'd0, prev_data});
        end
        if (io.fifo_rd_en === 1'b1) begin
          chk("rd_nonempty", {31'd0, wr_ptr != rd_ptr}, 32'd1);
          if (have_rd) chk("rd_gap_ge3", {31'd0, (cyc - last_rd) >= 3}, 32'd1);
          last_rd = cyc;
          have_rd = 1'b1;
        end
        chk("owed_le2", {31'd0, (rd_ptr - out_ptr) <= 2}, 32'd1);
        if (io.m_valid === 1'b1 && io.m_ready === 1'b1) begin
          chk("beat_data", {16'd0, io.m_data}, {16'd0, fifo_mem[out_ptr % 4096]});
          out_log.push_back(io.m_data);
          out_ptr++;
          hs_cnt++;
        end
        prev_stall = (io.m_valid === 1'b1) && (io.m_ready !== 1'b1);
        prev_data = io.m_data;
      end
    end
  endtask

  initial begin
    int unsigned      hs0;
    int               pulses;
    logic [WIDTH-1:0] w[5];
    int unsigned      nrand;

    rst = 1'b1;
    en = 1'b0;
    io.m_ready = 1'b0;
    force_err = 1'b0;
    wr_ptr = 0;
    fork
      monitor();
    join_none

    // Reset state
    tick();
    tick();
    chk("rst_valid", {31'd0, io.m_valid}, 32'd0);
    chk("rst_rd_en", {31'd0, io.fifo_rd_en}, 32'd0);
    chk("rst_data", {16'd0, io.m_data}, 32'd0);
    chk("rst_err", {24'd0, err_cnt}, 32'd0);
    chk("rst_beat", {16'd0, beat_cnt}, 32'd0);
    rst = 1'b0;

    // Four words, free-flowing: in order, reads exactly 3 cycles apart
    hs0 = hs_cnt;
    for (int i = 1; i <= 4; i++) push(WIDTH'(i));
    en = 1'b1;
    io.m_ready = 1'b1;
    tq.delete();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (io.fifo_rd_en === 1'b1) tq.push_back(k);
    end
    chk("t1_reads", tq.size(), 32'd4);
    for (int i = 1; i < 4 && i < tq.size(); i++) chk("t1_pulse_spacing", tq[i] - tq[i-1], 32'd3);
    chk("t1_beats", hs_cnt - hs0, 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_word", {16'd0, out_log[hs0 + i]}, i + 1);
    chk("t1_err", {24'd0, err_cnt}, 32'd0);
    chk("t1_beat_cnt", {16'd0, beat_cnt}, BEAT_EN ? 32'd4 : 32'd0);

    // Backpressure: five words, only two reads while stalled, head held
    io.m_ready = 1'b0;
    hs0 = hs_cnt;
    for (int i = 0; i < 5; i++) begin
      w[i] = WIDTH'($urandom);
      push(w[i]);
    end
    count_rd(30, pulses);
    chk("t2_stalled_reads", pulses, 32'd2);
    chk("t2_valid", {31'd0, io.m_valid}, 32'd1);
    chk("t2_head", {16'd0, io.m_data}, {16'd0, w[0]});
    io.m_ready = 1'b1;
    for (int k = 0; k < 40; k++) tick();
    chk("t2_beats", hs_cnt - hs0, 32'd5);
    for (int i = 0; i < 5; i++) chk("t2_word", {16'd0, out_log[hs0 + i]}, {16'd0, w[i]});

    // Single word: one read, valid exactly two cycles later, then quiet
    io.m_ready = 1'b0;
    hs0 = hs_cnt;
    push(16'hBEEF);
    wait_rd("t3_rd_seen");
    tick();
    chk("t3_valid_t1", {31'd0, io.m_valid}, 32'd0);
    tick();
    chk("t3_valid_t2", {31'd0, io.m_valid}, 32'd1);
    chk("t3_data", {16'd0, io.m_data}, 32'h0000BEEF);
    count_rd(10, pulses);
    chk("t3_no_more_reads", pulses, 32'd0);
    io.m_ready = 1'b1;
    tick();
    tick();
    chk("t3_beats", hs_cnt - hs0, 32'd1);

    // en_i dropped during ISSUE: read completes, nothing more until re-enabled
    hs0 = hs_cnt;
    w[0] = WIDTH'($urandom);
    w[1] = WIDTH'($urandom);
    push(w[0]);
    push(w[1]);
    wait_rd("t4_rd_seen");
    en = 1'b0;
    count_rd(15, pulses);
    chk("t4_reads_while_off", pulses, 32'd0);
    chk("t4_beats_off", hs_cnt - hs0, 32'd1);
    chk("t4_word0", {16'd0, out_log[hs0]}, {16'd0, w[0]});
    en = 1'b1;
    count_rd(15, pulses);
    chk("t4_reads_on", pulses, 32'd1);
    chk("t4_beats_on", hs_cnt - hs0, 32'd2);
    chk("t4_word1", {16'd0, out_log[hs0 + 1]}, {16'd0, w[1]});

    // Read-error counter: exact count, then saturation
    chk("t5_err0", {24'd0, err_cnt}, 32'd0);
    force_err = 1'b1;
    repeat (100) tick();
    chk("t5_err100", {24'd0, err_cnt}, 32'd100);
    repeat (200) tick();
    chk("t5_err_sat", {24'd0, err_cnt}, 32'd255);
    force_err = 1'b0;
    repeat (5) tick();
    chk("t5_err_hold", {24'd0, err_cnt}, 32'd255);

    // Randomized traffic: random enable, backpressure and FIFO fill
    hs0 = hs_cnt;
    nrand = 0;
    for (int k = 0; k < 600; k++) begin
      en = ($urandom_range(0, 7) != 0);
      io.m_ready = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) begin
        push(WIDTH'($urandom));
        nrand++;
      end
      tick();
    end
    en = 1'b1;
    io.m_ready = 1'b1;
    for (int k = 0; k < 400 && out_ptr != wr_ptr; k++) tick();
    chk("rnd_delivered", hs_cnt - hs0, nrand);
    chk("rnd_err_hold", {24'd0, err_cnt}, 32'd255);

    // Reset in CAPTURE with one word buffered: both words lost, stream restarts clean
    io.m_ready = 1'b0;
    hs0 = hs_cnt;
    push(WIDTH'($urandom));
    push(WIDTH'($urandom));
    wait_rd("t6_rd_a");
    wait_rd("t6_rd_b");
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_valid", {31'd0, io.m_valid}, 32'd0);
    chk("t6_rd_en", {31'd0, io.fifo_rd_en}, 32'd0);
    chk("t6_data", {16'd0, io.m_data}, 32'd0);
    chk("t6_err", {24'd0, err_cnt}, 32'd0);
    chk("t6_beat0", {16'd0, beat_cnt}, 32'd0);
    io.m_ready = 1'b1;
    repeat (10) tick();
    chk("t6_no_output", hs_cnt - hs0, 32'd0);
    chk("t6_still_idle", {31'd0, io.m_valid}, 32'd0);
    for (int i = 0; i < 3; i++) push(WIDTH'($urandom));
    repeat (20) tick();
    chk("t6_beats", hs_cnt - hs0, 32'd3);
    chk("t6_beat3", {16'd0, beat_cnt}, BEAT_EN ? 32'd3 : 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
